srio_link_monitor: RTL and testbench



---
 rtl/srio_link_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_srio_link_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_link_monitor.sv
// Serial RapidIO link bring-up monitor.
// Per channel, the raw lock / port / link / 1x status bits are synchronised
// and debounced. A bring-up FSM with a shared lock-to-link timeout budget
// then tracks each channel.
// Ports:
//   sys_clk, sys_rst           single clock, synchronous active-high reset
//   clk_lock_i, port_init_i,
//   link_init_i, mode_1x_i     raw endpoint status, one bit per channel
//   retrain_i                  one-cycle request forcing a channel to IDLE
//   clear_cnt_i                clears counters and sticky timeouts
//   state_o                    3-bit FSM state per channel
//   link_up_o, all_up_o        per-channel UP flag, registered AND of all
//   mode_1x_o                  filtered 1x-mode flag
//   *_pulse_o                  one-cycle bring-up / link-down events
//   timeout_o                  sticky, set on entry to FAIL
//   up_cnt_o, down_cnt_o       saturating UP entry / exit counters
module srio_link_monitor #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned DEBOUNCE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [CHANNELS-1:0]       clk_lock_i,
    input  logic [CHANNELS-1:0]       port_init_i,
    input  logic [CHANNELS-1:0]       link_init_i,
    input  logic [CHANNELS-1:0]       mode_1x_i,
    input  logic [CHANNELS-1:0]       retrain_i,
    input  logic                      clear_cnt_i,
    output logic [3*CHANNELS-1:0]     state_o,
    output logic [CHANNELS-1:0]       link_up_o,
    output logic                      all_up_o,
    output logic [CHANNELS-1:0]       mode_1x_o,
    output logic [CHANNELS-1:0]       port_up_pulse_o,
    output logic [CHANNELS-1:0]       link_up_pulse_o,
    output logic [CHANNELS-1:0]       link_down_pulse_o,
    output logic [CHANNELS-1:0]       timeout_o,
    output logic [CNT_W*CHANNELS-1:0] up_cnt_o,
    output logic [CNT_W*CHANNELS-1:0] down_cnt_o
);

    localparam int unsigned NB = 4 * CHANNELS;
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0]    RUN_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PORT = 3'd1,
        S_WAIT_LINK = 3'd2,
        S_UP        = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    // Conditioned bits are laid out as {mode, link, port, lock}.
    logic [NB-1:0]       raw_w;
    logic [NB-1:0]       sync1_q, sync2_q;
    logic [NB-1:0]       filt_q, filt_d;
    logic [DW-1:0]       run_q [NB];
    logic [DW-1:0]       run_d [NB];

    logic [CHANNELS-1:0] retrain_q;
    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [TW-1:0]       timer_q [CHANNELS];
    logic [TW-1:0]       timer_d [CHANNELS];
    logic [CNT_W-1:0]    up_q    [CHANNELS];
    logic [CNT_W-1:0]    up_d    [CHANNELS];
    logic [CNT_W-1:0]    down_q  [CHANNELS];
    logic [CNT_W-1:0]    down_d  [CHANNELS];
    logic [CHANNELS-1:0] timeout_q, timeout_d;
    logic [CHANNELS-1:0] link_up_q, link_up_d;
    logic [CHANNELS-1:0] pu_q, pu_d, lu_q, lu_d, ld_q, ld_d;
    logic                all_up_q;

    assign raw_w = {mode_1x_i, link_init_i, port_init_i, clk_lock_i};

    // Debounce: a bit follows the synchronised value only after it has
    // disagreed for DEBOUNCE consecutive cycles; any agreement restarts.
    always_comb begin
        filt_d = filt_q;
        for (int b = 0; b < int'(NB); b++) begin
            run_d[b] = '0;
            if (sync2_q[b] != filt_q[b]) begin
                if (run_q[b] == RUN_LAST) begin
                    filt_d[b] = sync2_q[b];
                end else begin
                    run_d[b] = run_q[b] + DW'(1);
                end
            end
        end
    end

    // Per-channel bring-up FSM, timer, events and counters.
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            logic lock, port, link, timed_out;
            state_d[c]   = state_q[c];
            timer_d[c]   = timer_q[c];
            up_d[c]      = up_q[c];
            down_d[c]    = down_q[c];
            timeout_d[c] = timeout_q[c];
            pu_d[c]      = 1'b0;
            lu_d[c]      = 1'b0;
            ld_d[c]      = 1'b0;
            link_up_d[c] = 1'b0;

            lock      = filt_q[c];
            port      = filt_q[CHANNELS + c];
            link      = filt_q[2*CHANNELS + c];
            timed_out = (timer_q[c] == TMR_LAST);

            // Shared budget across WAIT_PORT/WAIT_LINK; saturating so a
            // last-cycle progress step cannot wrap into a fresh budget.
            if ((state_q[c] == S_WAIT_PORT || state_q[c] == S_WAIT_LINK) && !timed_out) begin
                timer_d[c] = timer_q[c] + TW'(1);
            end

            if (retrain_q[c]) begin
                state_d[c] = S_IDLE;
            end else begin
                case (state_q[c])
                    S_IDLE: begin
                        if (lock) begin
                            state_d[c] = S_WAIT_PORT;
                            timer_d[c] = '0;
                        end
                    end
                    S_WAIT_PORT: begin
                        if (!lock)          state_d[c] = S_IDLE;
                        else if (port)      state_d[c] = S_WAIT_LINK;
                        else if (timed_out) state_d[c] = S_FAIL;
                    end
                    S_WAIT_LINK: begin
                        if (!lock)          state_d[c] = S_IDLE;
                        else if (!port)     state_d[c] = S_WAIT_PORT;
                        else if (link)      state_d[c] = S_UP;
                        else if (timed_out) state_d[c] = S_FAIL;
                    end
                    S_UP: begin
                        if (!lock)          state_d[c] = S_IDLE;
                        else if (!port)     state_d[c] = S_WAIT_PORT;
                        else if (!link)     state_d[c] = S_WAIT_LINK;
                    end
                    S_FAIL: begin
                        if (!lock)          state_d[c] = S_IDLE;
                    end
                    default: state_d[c] = S_IDLE;
                endcase
            end

            pu_d[c]      = (state_q[c] == S_WAIT_PORT) && (state_d[c] == S_WAIT_LINK);
            lu_d[c]      = (state_q[c] != S_UP) && (state_d[c] == S_UP);
            ld_d[c]      = (state_q[c] == S_UP) && (state_d[c] != S_UP);
            link_up_d[c] = (state_d[c] == S_UP);
            if (ld_d[c]) begin
                timer_d[c] = '0;
            end

            // Clear beats any same-cycle increment or sticky set.
            if (clear_cnt_i) begin
                up_d[c]      = '0;
                down_d[c]    = '0;
                timeout_d[c] = 1'b0;
            end else begin
                if (lu_d[c] && up_q[c] != CNT_MAX)   up_d[c]   = up_q[c] + CNT_W'(1);
                if (ld_d[c] && down_q[c] != CNT_MAX) down_d[c] = down_q[c] + CNT_W'(1);
                if (state_q[c] != S_FAIL && state_d[c] == S_FAIL) timeout_d[c] = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            retrain_q <= '0;
            timeout_q <= '0;
            link_up_q <= '0;
            pu_q      <= '0;
            lu_q      <= '0;
            ld_q      <= '0;
            all_up_q  <= 1'b0;
            for (int b = 0; b < int'(NB); b++) begin
                run_q[b] <= '0;
            end
            for (int c = 0; c < int'(CHANNELS); c++) begin
                state_q[c] <= S_IDLE;
                timer_q[c] <= '0;
                up_q[c]    <= '0;
                down_q[c]  <= '0;
            end
        end else begin
            sync1_q   <= raw_w;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            retrain_q <= retrain_i;
            timeout_q <= timeout_d;
            link_up_q <= link_up_d;
            pu_q      <= pu_d;
            lu_q      <= lu_d;
            ld_q      <= ld_d;
            all_up_q  <= &link_up_q;
            for (int b = 0; b < int'(NB); b++) begin
                run_q[b] <= run_d[b];
            end
            for (int c = 0; c < int'(CHANNELS); c++) begin
                state_q[c] <= state_d[c];
                timer_q[c] <= timer_d[c];
                up_q[c]    <= up_d[c];
                down_q[c]  <= down_d[c];
            end
        end
    end

    // Output packing.
    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_out
        assign state_o[c*3 +: 3]        = state_q[c];
        assign up_cnt_o[c*CNT_W +: CNT_W]   = up_q[c];
        assign down_cnt_o[c*CNT_W +: CNT_W] = down_q[c];
    end

    assign link_up_o         = link_up_q;
    assign all_up_o          = all_up_q;
    assign mode_1x_o         = filt_q[3*CHANNELS +: CHANNELS];
    assign port_up_pulse_o   = pu_q;
    assign link_up_pulse_o   = lu_q;
    assign link_down_pulse_o = ld_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_srio_link_monitor.sv
// Scoreboard bench for srio_link_monitor: a driver applies stimulus on the
// falling edge and queues the reference model's post-edge outputs; a monitor
// pops one entry after every rising edge and compares.
module tb_srio_link_monitor;

    localparam int CH  = 2;
    localparam int DB  = 4;
    localparam int TO  = 100;
    localparam int CW  = 4;
    localparam int NB  = 4 * CH;
    localparam int CMAX = (1 << CW) - 1;

    localparam int IDLE = 0, WPORT = 1, WLINK = 2, UPST = 3, FAILST = 4;

    typedef struct packed {
        logic [3*CH-1:0]  state;
        logic [CH-1:0]    link_up;
        logic             all_up;
        logic [CH-1:0]    mode;
        logic [CH-1:0]    pu;
        logic [CH-1:0]    lu;
        logic [CH-1:0]    ld;
        logic [CH-1:0]    to;
        logic [CW*CH-1:0] up;
        logic [CW*CH-1:0] dn;
    } exp_t;

    logic clk;
    logic rst;
    logic [CH-1:0] lock, port, link, mode, retrain;
    logic clear;

    logic [3*CH-1:0]  state_o;
    logic [CH-1:0]    link_up_o, mode_1x_o, pu_o, lu_o, ld_o, to_o;
    logic             all_up_o;
    logic [CW*CH-1:0] up_o, dn_o;

    srio_link_monitor #(
        .CHANNELS(CH), .DEBOUNCE(DB), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .sys_clk(clk), .sys_rst(rst),
        .clk_lock_i(lock), .port_init_i(port), .link_init_i(link),
        .mode_1x_i(mode), .retrain_i(retrain), .clear_cnt_i(clear),
        .state_o(state_o), .link_up_o(link_up_o), .all_up_o(all_up_o),
        .mode_1x_o(mode_1x_o), .port_up_pulse_o(pu_o),
        .link_up_pulse_o(lu_o), .link_down_pulse_o(ld_o),
        .timeout_o(to_o), .up_cnt_o(up_o), .down_cnt_o(dn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t expq[$];

    // ---------------- reference model ----------------
    int         m_st [CH];
    int         m_el [CH];   // cycles spent in the bring-up budget
    int         m_up [CH];
    int         m_dn [CH];
    bit         m_to [CH];
    bit         m_lu [CH];
    bit         m_all;
    logic [CH-1:0] m_rt;
    logic [NB-1:0] m_filt;
    logic [NB-1:0] m_pipe[$];  // raw samples still inside the synchroniser
    logic [NB-1:0] m_hist[$];  // last DB synchronised samples

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_st[c] = IDLE; m_el[c] = 0; m_up[c] = 0; m_dn[c] = 0;
            m_to[c] = 0; m_lu[c] = 0;
        end
        m_all = 0; m_rt = '0; m_filt = '0;
        m_pipe.delete(); m_pipe.push_back('0); m_pipe.push_back('0);
        m_hist.delete();
    endtask

    task automatic model_step(output exp_t e);
        bit newall;
        logic [NB-1:0] s;
        e = '0;
        if (rst) begin
            model_reset();
            return;
        end
        newall = 1;
        for (int c = 0; c < CH; c++) newall &= m_lu[c];
        for (int c = 0; c < CH; c++) begin
            bit lk, pt, ln, pu, lu, ld;
            int nx;
            lk = m_filt[c]; pt = m_filt[CH + c]; ln = m_filt[2*CH + c];
            nx = m_st[c];
            if (m_rt[c]) nx = IDLE;
            else if (m_st[c] == IDLE) begin
                if (lk) nx = WPORT;
            end else if (!lk) nx = IDLE;
            else if (m_st[c] == WPORT) begin
                if (pt) nx = WLINK;
                else if (m_el[c] + 1 >= TO) nx = FAILST;
            end else if (m_st[c] == WLINK) begin
                if (!pt) nx = WPORT;
                else if (ln) nx = UPST;
                else if (m_el[c] + 1 >= TO) nx = FAILST;
            end else if (m_st[c] == UPST) begin
                if (!pt) nx = WPORT;
                else if (!ln) nx = WLINK;
            end
            pu = (m_st[c] == WPORT) && (nx == WLINK);
            lu = (m_st[c] != UPST) && (nx == UPST);
            ld = (m_st[c] == UPST) && (nx != UPST);
            if (m_st[c] == IDLE && nx == WPORT) m_el[c] = 0;
            else if (ld) m_el[c] = 0;
            else if (m_st[c] == WPORT || m_st[c] == WLINK) m_el[c]++;
            if (clear) begin
                m_up[c] = 0; m_dn[c] = 0; m_to[c] = 0;
            end else begin
                if (lu && m_up[c] < CMAX) m_up[c]++;
                if (ld && m_dn[c] < CMAX) m_dn[c]++;
                if (nx == FAILST && m_st[c] != FAILST) m_to[c] = 1;
            end
            m_st[c] = nx;
            m_lu[c] = (nx == UPST);
            e.state[c*3 +: 3] = 3'(nx);
            e.link_up[c] = m_lu[c];
            e.pu[c] = pu; e.lu[c] = lu; e.ld[c] = ld;
            e.to[c] = m_to[c];
            e.up[c*CW +: CW] = CW'(m_up[c]);
            e.dn[c*CW +: CW] = CW'(m_dn[c]);
        end
        m_all = newall;
        e.all_up = m_all;
        // Synchroniser delay then debounce: flip once DB samples all disagree.
        s = m_pipe.pop_front();
        m_pipe.push_back({mode, link, port, lock});
        m_hist.push_back(s);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        if (m_hist.size() == DB) begin
            for (int b = 0; b < NB; b++) begin
                bit all_diff;
                all_diff = 1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_filt[b]) all_diff = 0;
                if (all_diff) m_filt[b] = ~m_filt[b];
            end
        end
        e.mode = m_filt[3*CH +: CH];
        m_rt = retrain;
    endtask

    // ---------------- driver ----------------
    task automatic step(int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_step(e);
            expq.push_back(e);
            @(negedge clk);
            retrain = '0;
            clear = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("state",     64'(state_o),   64'(e.state));
                chk("link_up",   64'(link_up_o), 64'(e.link_up));
                chk("all_up",    64'(all_up_o),  64'(e.all_up));
                chk("mode_1x",   64'(mode_1x_o), 64'(e.mode));
                chk("port_up_p", 64'(pu_o),      64'(e.pu));
                chk("link_up_p", 64'(lu_o),      64'(e.lu));
                chk("link_dn_p", 64'(ld_o),      64'(e.ld));
                chk("timeout",   64'(to_o),      64'(e.to));
                chk("up_cnt",    64'(up_o),      64'(e.up));
                chk("down_cnt",  64'(dn_o),      64'(e.dn));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; lock = '0; port = '0; link = '0; mode = '0;
        retrain = '0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        step(5);
        rst = 1'b0;
        step(3);

        // Bring-up of ch0 then ch1.
        for (int c = 0; c < CH; c++) begin
            mode[c] = 1'($urandom_range(0, 1));
            lock[c] = 1'b1; step(20);
            port[c] = 1'b1; step(20);
            link[c] = 1'b1; step(15);
        end

        // Link glitches on ch0 while UP: 3 cycles filtered, 4 cycles not.
        link[0] = 1'b0; step(3); link[0] = 1'b1; step(12);
        link[0] = 1'b0; step(4); link[0] = 1'b1; step(15);
        lock[0] = 1'b0; step(15);

        // Timeout with lock only, retrain, then clear.
        rst = 1'b1; step(2); rst = 1'b0;
        lock = '0; port = '0; link = '0;
        lock[0] = 1'b1; step(120);
        retrain[0] = 1'b1; step(15);
        step(110);
        clear = 1'b1; step(5);

        // Counter saturation with 20 up/down cycles.
        lock[0] = 1'b0; step(10);
        lock[0] = 1'b1; port[0] = 1'b1; step(12);
        for (int i = 0; i < 20; i++) begin
            link[0] = 1'b1; step(10);
            link[0] = 1'b0; step(10);
        end

        // Clear in the cycle of UP entry.
        link[0] = 1'b1; step(6); clear = 1'b1; step(10);
        // Retrain coinciding with filtered link rise.
        link[0] = 1'b0; step(12);
        link[0] = 1'b1; step(5); retrain[0] = 1'b1; step(15);

        // Reset mid-bring-up.
        lock[1] = 1'b1; port[1] = 1'b0; step(12);
        rst = 1'b1; step(1); rst = 1'b0; step(5);

        // Randomised traffic, first noisy, then mostly-stable.
        for (int i = 0; i < 3000; i++) begin
            int sl;
            sl = (i < 1500) ? 12 : 60;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, sl * 2) == 0) lock[c] = ~lock[c];
                if ($urandom_range(0, sl) == 0) port[c] = ~port[c];
                if ($urandom_range(0, sl) == 0) link[c] = ~link[c];
                if ($urandom_range(0, 30) == 0) mode[c] = ~mode[c];
                if ($urandom_range(0, 150) == 0) retrain[c] = 1'b1;
            end
            if ($urandom_range(0, 250) == 0) clear = 1'b1;
            rst = ($urandom_range(0, 1500) == 0);
            step(1);
        end
        rst = 1'b0;
        step(3);
        @(negedge clk);
        @(negedge clk);
        chk("drained", 64'(expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
